// File: rtl/snitch_narrow_id_remap.sv
`default_nettype none
// ============================================================================
//  Module   : snitch_narrow_id_remap
//  Purpose  : Compacts the wide narrow-crossbar AXI IDs into table-index IDs
//             on the downstream port. The original IDs are restored on R/B.
//             The read (AR/R) and write (AW/B) tables are independent.
//  Options  : SNITCH_ID_REMAP_PERF_EN - enables the stall-cycle counter
//             (stall_cnt_o). When it is undefined, the output is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================

// Narrow-path AXI types for the cluster. Only the upstream ("out") and
// downstream ("in") ID widths differ.
package snitch_cluster_cfg_pkg;
    localparam int unsigned NarrowIdWidthIn  = 2;
    localparam int unsigned NarrowIdWidthOut = 5;
    localparam int unsigned NarrowAddrWidth  = 48;
    localparam int unsigned NarrowDataWidth  = 64;

    typedef struct packed {
        logic [NarrowIdWidthOut-1:0] id;
        logic [NarrowAddrWidth-1:0]  addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
    } narrow_out_ax_chan_t;

    typedef struct packed {
        logic [NarrowIdWidthIn-1:0]  id;
        logic [NarrowAddrWidth-1:0]  addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
    } narrow_in_ax_chan_t;

    typedef struct packed {
        logic [NarrowDataWidth-1:0]   data;
        logic [NarrowDataWidth/8-1:0] strb;
        logic                         last;
    } narrow_w_chan_t;

    typedef struct packed {
        logic [NarrowIdWidthOut-1:0] id;
        logic [1:0]                  resp;
    } narrow_out_b_chan_t;

    typedef struct packed {
        logic [NarrowIdWidthIn-1:0]  id;
        logic [1:0]                  resp;
    } narrow_in_b_chan_t;

    typedef struct packed {
        logic [NarrowIdWidthOut-1:0] id;
        logic [NarrowDataWidth-1:0]  data;
        logic [1:0]                  resp;
        logic                        last;
    } narrow_out_r_chan_t;

    typedef struct packed {
        logic [NarrowIdWidthIn-1:0]  id;
        logic [NarrowDataWidth-1:0]  data;
        logic [1:0]                  resp;
        logic                        last;
    } narrow_in_r_chan_t;

    typedef struct packed {
        narrow_out_ax_chan_t aw;
        logic                aw_valid;
        narrow_w_chan_t      w;
        logic                w_valid;
        logic                b_ready;
        narrow_out_ax_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } narrow_out_req_t;

    typedef struct packed {
        logic                aw_ready;
        logic                ar_ready;
        logic                w_ready;
        narrow_out_b_chan_t  b;
        logic                b_valid;
        narrow_out_r_chan_t  r;
        logic                r_valid;
    } narrow_out_resp_t;

    typedef struct packed {
        narrow_in_ax_chan_t  aw;
        logic                aw_valid;
        narrow_w_chan_t      w;
        logic                w_valid;
        logic                b_ready;
        narrow_in_ax_chan_t  ar;
        logic                ar_valid;
        logic                r_ready;
    } narrow_in_req_t;

    typedef struct packed {
        logic                aw_ready;
        logic                ar_ready;
        logic                w_ready;
        narrow_in_b_chan_t   b;
        logic                b_valid;
        narrow_in_r_chan_t   r;
        logic                r_valid;
    } narrow_in_resp_t;
endpackage

module snitch_narrow_id_remap
    import snitch_cluster_cfg_pkg::*;
#(
    parameter int unsigned SlvIdWidth   = NarrowIdWidthOut,
    parameter int unsigned MstIdWidth   = NarrowIdWidthIn,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  narrow_out_req_t  slv_req_i,
    output narrow_out_resp_t slv_resp_o,
    output narrow_in_req_t   mst_req_o,
    input  narrow_in_resp_t  mst_resp_i,
    output logic [31:0]      stall_cnt_o
);

    localparam int unsigned c_idx_w = $clog2(MaxUniqIds);
    localparam int unsigned c_cnt_w = $clog2(MaxTxnsPerId + 1);

    // Reject configurations that cannot carry the table index downstream.
    if ((MstIdWidth < c_idx_w) || (MaxUniqIds < 2) ||
        ((MaxUniqIds & (MaxUniqIds - 1)) != 0)) begin : g_bad_cfg
        $error("snitch_narrow_id_remap: invalid MstIdWidth/MaxUniqIds");
    end

    // Index 0 is the read table and index 1 is the write table.
    logic [1:0]            w_req_valid;
    logic [1:0]            w_req_ready_dn;
    logic [SlvIdWidth-1:0] w_req_id  [2];
    logic [1:0]            w_rsp_dec;
    logic [c_idx_w-1:0]    w_rsp_idx [2];
    logic [1:0]            w_stall;
    logic [c_idx_w-1:0]    w_sel_idx [2];
    logic [SlvIdWidth-1:0] w_rsp_sid [2];

    assign w_req_valid    = {slv_req_i.aw_valid, slv_req_i.ar_valid};
    assign w_req_ready_dn = {mst_resp_i.aw_ready, mst_resp_i.ar_ready};
    assign w_req_id[0]    = slv_req_i.ar.id;
    assign w_req_id[1]    = slv_req_i.aw.id;
    assign w_rsp_idx[0]   = mst_resp_i.r.id[c_idx_w-1:0];
    assign w_rsp_idx[1]   = mst_resp_i.b.id[c_idx_w-1:0];
    // A read transaction is released only by its final R beat. Every B releases one write.
    assign w_rsp_dec[0]   = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign w_rsp_dec[1]   = mst_resp_i.b_valid && slv_req_i.b_ready;

    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [MaxUniqIds-1:0] r_vld;
        logic [SlvIdWidth-1:0] r_sid [MaxUniqIds];
        logic [c_cnt_w-1:0]    r_cnt [MaxUniqIds];

        logic                  w_match_any;
        logic [c_idx_w-1:0]    w_match_idx;
        logic                  w_free_any;
        logic [c_idx_w-1:0]    w_free_idx;
        logic                  w_hit_ok;
        logic                  w_alloc;
        logic                  w_inc;
        logic [MaxUniqIds-1:0] w_inc_vec;
        logic [MaxUniqIds-1:0] w_dec_vec;

        // Look up the matching entry and the lowest free entry. Both use registered state only.
        always_comb begin
            w_match_any = 1'b0;
            w_match_idx = '0;
            w_free_any  = 1'b0;
            w_free_idx  = '0;
            for (int e = 0; e < int'(MaxUniqIds); e++) begin
                if (r_vld[e] && (r_sid[e] == w_req_id[d])) begin
                    w_match_any = 1'b1;
                    w_match_idx = c_idx_w'(e);
                end
            end
            for (int e = int'(MaxUniqIds) - 1; e >= 0; e--) begin
                if (!r_vld[e]) begin
                    w_free_any = 1'b1;
                    w_free_idx = c_idx_w'(e);
                end
            end
        end

        assign w_hit_ok     = w_match_any && (r_cnt[w_match_idx] != c_cnt_w'(MaxTxnsPerId));
        assign w_alloc      = !w_match_any && w_free_any;
        assign w_stall[d]   = !(w_hit_ok || w_alloc);
        assign w_sel_idx[d] = w_match_any ? w_match_idx : w_free_idx;
        assign w_inc        = w_req_valid[d] && !w_stall[d] && w_req_ready_dn[d];
        assign w_rsp_sid[d] = r_sid[w_rsp_idx[d]];

        // Build one-hot increment and decrement strobes for each entry.
        always_comb begin
            w_inc_vec = '0;
            w_dec_vec = '0;
            for (int e = 0; e < int'(MaxUniqIds); e++) begin
                w_inc_vec[e] = w_inc && (w_sel_idx[d] == c_idx_w'(e));
                w_dec_vec[e] = w_rsp_dec[d] && (w_rsp_idx[d] == c_idx_w'(e));
            end
        end

        // Update the table. An allocation wins, and a same-cycle inc and dec leave the entry unchanged.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_vld <= '0;
                for (int e = 0; e < int'(MaxUniqIds); e++) begin
                    r_sid[e] <= '0;
                    r_cnt[e] <= '0;
                end
            end else begin
                for (int e = 0; e < int'(MaxUniqIds); e++) begin
                    if (w_inc_vec[e] && w_alloc) begin
                        r_vld[e] <= 1'b1;
                        r_sid[e] <= w_req_id[d];
                        r_cnt[e] <= c_cnt_w'(1);
                    end else if (w_inc_vec[e] && !w_dec_vec[e]) begin
                        r_cnt[e] <= r_cnt[e] + c_cnt_w'(1);
                    end else if (w_dec_vec[e] && !w_inc_vec[e]) begin
                        r_cnt[e] <= r_cnt[e] - c_cnt_w'(1);
                        if (r_cnt[e] == c_cnt_w'(1)) begin
                            r_vld[e] <= 1'b0;
                        end
                    end
                end
            end
        end

`ifndef SYNTHESIS
        // A response must target a live entry. A live entry always holds cnt >= 1.
        a_rsp_to_valid_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_rsp_dec[d] |-> r_vld[w_rsp_idx[d]]);
`endif
    end

    // Forward the requests with compact IDs and restore the original IDs on responses.
    always_comb begin
        mst_req_o  = '0;
        slv_resp_o = '0;

        mst_req_o.aw.id    = MstIdWidth'(w_sel_idx[1]);
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.size  = slv_req_i.aw.size;
        mst_req_o.aw.burst = slv_req_i.aw.burst;
        mst_req_o.aw.cache = slv_req_i.aw.cache;
        mst_req_o.aw.prot  = slv_req_i.aw.prot;
        mst_req_o.aw_valid = slv_req_i.aw_valid && !w_stall[1];

        mst_req_o.ar.id    = MstIdWidth'(w_sel_idx[0]);
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar.size  = slv_req_i.ar.size;
        mst_req_o.ar.burst = slv_req_i.ar.burst;
        mst_req_o.ar.cache = slv_req_i.ar.cache;
        mst_req_o.ar.prot  = slv_req_i.ar.prot;
        mst_req_o.ar_valid = slv_req_i.ar_valid && !w_stall[0];

        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.r_ready  = slv_req_i.r_ready;

        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !w_stall[1];
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !w_stall[0];
        slv_resp_o.w_ready  = mst_resp_i.w_ready;

        slv_resp_o.b.id     = w_rsp_sid[1];
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;

        slv_resp_o.r.id     = w_rsp_sid[0];
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
    end

`ifdef SNITCH_ID_REMAP_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count each cycle in which an AR or AW is held back by the table. The count increments once per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if ((slv_req_i.ar_valid && w_stall[0]) ||
                     (slv_req_i.aw_valid && w_stall[1])) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snitch_narrow_id_remap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snitch_narrow_id_remap
//  Purpose  : Directed, self-checking bench for snitch_narrow_id_remap.
//             A vector table drives the read path. Hand-written sequences
//             cover the write path, the perf counter and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snitch_narrow_id_remap;
    import snitch_cluster_cfg_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    narrow_out_req_t  slv_req;
    narrow_out_resp_t slv_resp;
    narrow_in_req_t   mst_req;
    narrow_in_resp_t  mst_resp;
    logic [31:0]      stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snitch_narrow_id_remap dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .stall_cnt_o (stall_cnt)
    );

    typedef struct {
        logic       ar_v;
        logic [4:0] ar_id;
        logic       ar_rdy;
        logic       r_v;
        logic [1:0] r_idx;
        logic       r_last;
        logic       exp_ar_v;
        logic [1:0] exp_ar_id;
        logic       exp_ar_rdy;
        logic [4:0] exp_r_id;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic ar_v, input logic [4:0] ar_id, input logic ar_rdy,
                              input logic r_v, input logic [1:0] r_idx, input logic r_last,
                              input logic e_v, input logic [1:0] e_id, input logic e_rdy,
                              input logic [4:0] e_rid);
        vec_t t;
        t.ar_v = ar_v; t.ar_id = ar_id; t.ar_rdy = ar_rdy;
        t.r_v = r_v; t.r_idx = r_idx; t.r_last = r_last;
        t.exp_ar_v = e_v; t.exp_ar_id = e_id; t.exp_ar_rdy = e_rdy; t.exp_r_id = e_rid;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        slv_req  = '0;
        mst_resp = '0;
        slv_req.r_ready  = 1'b1;
        slv_req.b_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.aw_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one AR that is expected to be accepted with the given index.
    task automatic ar_issue(input logic [4:0] id, input logic [1:0] exp_idx, input string name);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = id;
        @(negedge clk);
        chk({name, " ar_valid"}, 64'(mst_req.ar_valid), 64'd1);
        chk({name, " ar_id"}, 64'(mst_req.ar.id), 64'(exp_idx));
        step();
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset ar_valid", 64'(mst_req.ar_valid), 64'd0);
        chk("reset aw_valid", 64'(mst_req.aw_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Read-path vectors: AR, downstream ar_ready, R (index, last), and the expected values.
        // Single read, then an AR that reuses the freed entry 0.
        v(1, 5'h1A, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h1A);
        v(1, 5'h03, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h03);
        // Same-ID batching: 8 ARs fill entry 0, then the 9th AR stalls.
        for (int i = 0; i < 8; i++) v(1, 5'h05, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(1, 5'h05, 1, 0, 0, 0, 0, 0, 0, 5'h00);
        v(1, 5'h05, 1, 1, 0, 0, 0, 0, 0, 5'h05);   // a non-last R beat frees nothing
        v(1, 5'h05, 1, 0, 0, 0, 0, 0, 0, 5'h00);
        v(1, 5'h05, 1, 1, 0, 1, 0, 0, 0, 5'h05);   // R last, but the stall holds this cycle
        v(1, 5'h05, 1, 0, 0, 0, 1, 0, 1, 5'h00);   // the AR issues on the next cycle
        for (int i = 0; i < 8; i++) v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h05);
        // Simultaneous increment and decrement on entry 0 at cnt=1.
        v(1, 5'h11, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(1, 5'h11, 1, 1, 0, 1, 1, 0, 1, 5'h11);
        v(1, 5'h12, 1, 0, 0, 0, 1, 1, 1, 5'h00);   // entry 0 is still valid, so index 1 is used
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h11);   // cnt was 1, so entry 0 is freed
        v(1, 5'h13, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(0, 5'h00, 1, 1, 1, 1, 0, 0, 0, 5'h12);
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h13);
        // Table full: IDs 1..4 occupy all entries, so ID 7 stalls.
        v(1, 5'h01, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(1, 5'h02, 1, 0, 0, 0, 1, 1, 1, 5'h00);
        v(1, 5'h03, 1, 0, 0, 0, 1, 2, 1, 5'h00);
        v(1, 5'h04, 1, 0, 0, 0, 1, 3, 1, 5'h00);
        v(1, 5'h07, 1, 0, 0, 0, 0, 0, 0, 5'h00);
        v(1, 5'h07, 1, 1, 2, 1, 0, 0, 0, 5'h03);   // index 2 is freed, usable next cycle only
        v(1, 5'h07, 1, 0, 0, 0, 1, 2, 1, 5'h00);
        // Downstream backpressure: a hit without a handshake must not count.
        v(1, 5'h01, 0, 0, 0, 0, 1, 0, 0, 5'h00);
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h01);
        v(1, 5'h1E, 1, 0, 0, 0, 1, 0, 1, 5'h00);
        v(0, 5'h00, 1, 1, 0, 1, 0, 0, 0, 5'h1E);
        v(0, 5'h00, 1, 1, 1, 1, 0, 0, 0, 5'h02);
        v(0, 5'h00, 1, 1, 2, 1, 0, 0, 0, 5'h07);
        v(0, 5'h00, 1, 1, 3, 1, 0, 0, 0, 5'h04);

        do_reset();

        foreach (vecs[i]) begin
            slv_req.ar_valid  = vecs[i].ar_v;
            slv_req.ar.id     = vecs[i].ar_id;
            slv_req.ar.addr   = 48'h1000 + 48'(i);
            slv_req.ar.len    = 8'(i);
            mst_resp.ar_ready = vecs[i].ar_rdy;
            mst_resp.r_valid  = vecs[i].r_v;
            mst_resp.r.id     = vecs[i].r_idx;
            mst_resp.r.last   = vecs[i].r_last;
            mst_resp.r.data   = 64'hD000 + 64'(i);
            @(negedge clk);
            chk($sformatf("v%0d ar_valid", i), 64'(mst_req.ar_valid), 64'(vecs[i].exp_ar_v));
            if (vecs[i].ar_v) begin
                chk($sformatf("v%0d ar_ready", i), 64'(slv_resp.ar_ready), 64'(vecs[i].exp_ar_rdy));
            end
            if (vecs[i].exp_ar_v) begin
                chk($sformatf("v%0d ar_id", i), 64'(mst_req.ar.id), 64'(vecs[i].exp_ar_id));
                chk($sformatf("v%0d ar_addr", i), 64'(mst_req.ar.addr), 64'h1000 + 64'(i));
                chk($sformatf("v%0d ar_len", i), 64'(mst_req.ar.len), 64'(8'(i)));
            end
            if (vecs[i].r_v) begin
                chk($sformatf("v%0d r_id", i), 64'(slv_resp.r.id), 64'(vecs[i].exp_r_id));
                chk($sformatf("v%0d r_data", i), slv_resp.r.data, 64'hD000 + 64'(i));
                chk($sformatf("v%0d r_last", i), 64'(slv_resp.r.last), 64'(vecs[i].r_last));
            end
            step();
        end
        idle();

        // Write path: AW id 9 twice, then id 0x0A.
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 5'h09;
        slv_req.aw.addr  = 48'h2000;
        @(negedge clk);
        chk("aw9 valid", 64'(mst_req.aw_valid), 64'd1);
        chk("aw9 id", 64'(mst_req.aw.id), 64'd0);
        chk("aw9 addr", 64'(mst_req.aw.addr), 64'h2000);
        chk("aw9 ready", 64'(slv_resp.aw_ready), 64'd1);
        step();
        @(negedge clk);
        chk("aw9b id", 64'(mst_req.aw.id), 64'd0);
        step();
        slv_req.aw.id = 5'h0A;
        @(negedge clk);
        chk("awA id", 64'(mst_req.aw.id), 64'd1);
        step();
        slv_req.aw_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            slv_req.w_valid  = 1'b1;
            slv_req.w.data   = 64'hA5A5_0000 + 64'(b);
            slv_req.w.strb   = 8'hFF;
            slv_req.w.last   = (b == 3);
            mst_resp.w_ready = b[0];
            @(negedge clk);
            chk($sformatf("w%0d data", b), mst_req.w.data, 64'hA5A5_0000 + 64'(b));
            chk($sformatf("w%0d last", b), 64'(mst_req.w.last), 64'(b == 3));
            chk($sformatf("w%0d valid", b), 64'(mst_req.w_valid), 64'd1);
            chk($sformatf("w%0d ready", b), 64'(slv_resp.w_ready), 64'(b[0]));
            step();
        end
        slv_req.w_valid = 1'b0;
        // The read table is separate: id 0x0A gets read index 0, not the write index 1.
        ar_issue(5'h0A, 2'd0, "rd sep");
        mst_resp.r_valid = 1'b1; mst_resp.r.id = 2'd0; mst_resp.r.last = 1'b1;
        @(negedge clk);
        chk("rd sep r_id", 64'(slv_resp.r.id), 64'h0A);
        step();
        mst_resp.r_valid = 1'b0;
        // B responses: two for entry 0 (id 9), one for entry 1 (id 0x0A).
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd0; mst_resp.b.resp = 2'b01;
        @(negedge clk);
        chk("b9 id", 64'(slv_resp.b.id), 64'h09);
        chk("b9 valid", 64'(slv_resp.b_valid), 64'd1);
        chk("b9 resp", 64'(slv_resp.b.resp), 64'd1);
        step();
        @(negedge clk);
        chk("b9b id", 64'(slv_resp.b.id), 64'h09);
        step();
        mst_resp.b.id = 2'd1;
        @(negedge clk);
        chk("bA id", 64'(slv_resp.b.id), 64'h0A);
        step();
        mst_resp.b_valid = 1'b0;
        // After both B responses for id 9, write entry 0 is free again.
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 5'h0C;
        @(negedge clk);
        chk("awC id", 64'(mst_req.aw.id), 64'd0);
        step();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 2'd0;
        @(negedge clk);
        chk("bC id", 64'(slv_resp.b.id), 64'h0C);
        step();
        mst_resp.b_valid = 1'b0;

        // Perf counter: fill the read table, then hold a stalled AR for 10 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) ar_issue(5'(i + 1), 2'(i), "perf fill");
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 5'h07;
        @(negedge clk);
        chk("perf stalled", 64'(mst_req.ar_valid), 64'd0);
        chk("perf ar_ready", 64'(slv_resp.ar_ready), 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("perf ar held", 64'(mst_req.ar_valid), 64'd0);
        step();
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
`ifdef SNITCH_ID_REMAP_PERF_EN
        chk("perf stall_cnt", 64'(stall_cnt), 64'd10);
`else
        chk("perf stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        repeat (2) step();
        @(negedge clk);
`ifdef SNITCH_ID_REMAP_PERF_EN
        chk("perf stall_cnt idle", 64'(stall_cnt), 64'd10);
`else
        chk("perf stall_cnt idle", 64'(stall_cnt), 64'd0);
`endif

        // Reset mid-operation: the full table clears at once.
        step();
        rst_n = 1'b0;
        #2;
        chk("async rst stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        ar_issue(5'h07, 2'd0, "post rst");

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
